// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer between the PC register, instruction memory and decode.
// Define FETCH_STALL_CNT_EN to add a saturating 16-bit count of ungranted fetch cycles on stall_cnt.
module fetch_seq #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    Iaddr,
    output logic [PC_W-1:0]    Next_PC,
    output logic               imem_req,
    input  logic               imem_gnt,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 hp_q, hp_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        hp_d    = hp_q;
        if (state_q != HALT && redirect) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
            hp_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE:  state_d = halt ? HALT : FETCH;
                FETCH: begin
                    if (halt) begin
                        state_d = HALT;
                    end else if (imem_gnt) begin
                        instr_d = imem_rdata;
                        pc_d    = Iaddr + 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // a halt seen while holding waits until decode has taken the word
                    hp_d = hp_q | halt;
                    if (instr_ready) state_d = (hp_q | halt) ? HALT : FETCH;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            hp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            hp_q    <= hp_d;
        end
    end

    assign Next_PC     = pc_q;
    assign instr       = instr_q;
    assign imem_req    = state_q == FETCH;
    assign instr_valid = state_q == HOLD;
    assign halted      = state_q == HALT;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (state_q == FETCH && !imem_gnt && !redirect && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized scoreboard bench for fetch_seq with a transaction-level fetch model.
module tb_fetch_seq;
    localparam int PC_W = 10;
    localparam int IW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] Iaddr, Next_PC, redirect_pc;
    logic            imem_req, imem_gnt, instr_valid, instr_ready, redirect, halt, halted;
    logic [IW-1:0]   imem_rdata, instr;
    logic [15:0]     m_cnt, e_cnt;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    fetch_seq #(.PC_W(PC_W), .INSTR_W(IW)) dut (
        .clk(clk), .rst(rst), .Iaddr(Iaddr), .Next_PC(Next_PC),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
`ifdef FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // transparent PC register and a combinational memory read at the current PC
    logic [IW-1:0] mem [1024];
    assign Iaddr      = Next_PC;
    assign imem_rdata = mem[Iaddr];

    typedef struct {
        logic [PC_W-1:0] a;
        logic [IW-1:0]   w;
    } ent_t;
    ent_t q[$];

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;
    bit m_idle, m_halted, m_hp;
    logic [PC_W-1:0] m_addr, e_pc;
    bit e_req, e_valid, e_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares outputs against the model snapshot and drains the scoreboard
    always @(negedge clk) begin
        if (chk) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
            check("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
            check("halted", {31'b0, halted}, {31'b0, e_halted});
            check("Next_PC", {22'b0, Next_PC}, {22'b0, e_pc});
`ifdef FETCH_STALL_CNT_EN
            check("stall_cnt", {16'b0, stall_cnt}, {16'b0, e_cnt});
`endif
            if (e_valid && q.size() != 0) begin
                if (instr_valid) check("instr", instr, q[0].w);
                if (redirect || instr_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input bit g, input bit r, input bit rd, input logic [PC_W-1:0] rpc, input bit h);
        imem_gnt    = g;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
        e_req    = !m_halted && !m_idle && q.size() == 0;
        e_valid  = !m_halted && q.size() != 0;
        e_halted = m_halted;
        e_pc     = m_addr;
        e_cnt    = m_cnt;
        chk      = 1'b1;
        if (m_halted) begin
        end else if (rd) begin
            m_addr = rpc;
            m_hp   = 1'b0;
            m_idle = 1'b0;
        end else if (m_idle) begin
            m_idle   = 1'b0;
            m_halted = h;
        end else if (q.size() == 0) begin
            if (!g && m_cnt != 16'hFFFF) m_cnt++;
            if (h) m_halted = 1'b1;
            else if (g) begin
                q.push_back('{m_addr, mem[m_addr]});
                m_addr++;
            end
        end else begin
            if (h) m_hp = 1'b1;
            if (r && m_hp) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk = 1'b0;
        #3;
        rst = 1'b0;
        {imem_gnt, instr_ready, redirect, halt} = '0;
        redirect_pc = '0;
        #1;
        check("rst Next_PC", {22'b0, Next_PC}, 32'd0);
        check("rst imem_req", {31'b0, imem_req}, 32'd0);
        check("rst instr", instr, 32'd0);
        check("rst instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst halted", {31'b0, halted}, 32'd0);
        q.delete();
        m_idle = 1'b1; m_halted = 1'b0; m_hp = 1'b0; m_addr = '0; m_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic run(input int n, input int pg, input int pr, input int pred, input int ph);
        for (int i = 0; i < n; i++)
            step(pct(pg), pct(pr), pct(pred), pct(25) ? 10'd1022 : PC_W'($urandom_range(1023)), pct(ph));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1;
        do_reset();
        repeat (12) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 1, 10'h2A, 0);
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 10'd1022, 0);
        repeat (8) step(1, 1, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        repeat (7) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (6) step(1, 1, 1, PC_W'($urandom_range(1023)), 0);
        for (int k = 0; k < 8; k++) begin
            do_reset();
            run(250, 60, 50, 6, 1);
        end
        do_reset();
        run(400, 40, 30, 10, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
